// File: rtl/nano_prog_loader.sv
// Boot loader and program/data RAM for the NanoCPU: clears the RAM, loads an
// image over a valid/ready word stream, then serves the CPU memory port.
module nano_prog_loader #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          reload,
    output logic          cpu_rst,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_dataW,
    output logic [DW-1:0] cpu_dataR,
    input  logic          cpu_ce,
    input  logic          cpu_we,
    output logic [AW:0]   ld_count,
    output logic          ovf
);

    typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

    localparam state_t        BOOT_STATE = CLEAR_EN ? ST_CLEAR : ST_LOAD;
    localparam logic [AW-1:0] PTR_LAST   = '1;
    localparam logic [AW:0]   COUNT_MAX  = {1'b1, {AW{1'b0}}};

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   ld_count_q;
    logic          ovf_q;
    logic          cpu_rst_q;
    logic          ld_ready_q;
    logic [DW-1:0] mem_q [2**AW];

    logic          accept;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign accept = ld_valid && ld_ready_q;

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= BOOT_STATE;
            ptr_q      <= '0;
            ld_count_q <= '0;
            ovf_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
            ld_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_q    <= ST_LOAD;
                        ld_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    ld_ready_q <= 1'b1;
                    if (accept) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ld_count_q != COUNT_MAX) begin
                            ld_count_q <= ld_count_q + 1'b1;
                        end
                        // A full RAM ends the load even without ld_last; the rest of the stream is refused.
                        if (ld_last || (ptr_q == PTR_LAST)) begin
                            state_q    <= ST_RUN;
                            ovf_q      <= !ld_last;
                            cpu_rst_q  <= 1'b0;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        state_q    <= BOOT_STATE;
                        ptr_q      <= '0;
                        ld_count_q <= '0;
                        ovf_q      <= 1'b0;
                        cpu_rst_q  <= 1'b1;
                        ld_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= BOOT_STATE;
                    cpu_rst_q  <= 1'b1;
                    ld_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // One shared RAM write port: clearing, loading or the CPU, depending on state.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = '0;
        case (state_q)
            ST_CLEAR: wr_en = !rst;
            ST_LOAD: begin
                wr_en   = accept && !rst;
                wr_data = ld_data;
            end
            ST_RUN: begin
                wr_en   = cpu_ce && cpu_we && !rst;
                wr_addr = cpu_address;
                wr_data = cpu_dataW;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge ck) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign cpu_dataR = ((state_q == ST_RUN) && cpu_ce) ? mem_q[cpu_address] : '0;
    assign ld_ready  = ld_ready_q;
    assign cpu_rst   = cpu_rst_q;
    assign ld_count  = ld_count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nano_prog_loader.sv
// Scoreboard bench for nano_prog_loader: expected accepted words and CPU read
// data are queued by the stimulus and checked by an independent monitor.
module tb_nano_prog_loader;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          ck = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          reload;
    logic          cpu_rst;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_dataW;
    logic [DW-1:0] cpu_dataR;
    logic          cpu_ce;
    logic          cpu_we;
    logic [AW:0]   ld_count;
    logic          ovf;

    int nTests = 0;
    int nFail  = 0;

    logic [DW-1:0] accQ[$];
    logic [DW-1:0] rdQ[$];

    nano_prog_loader #(.AW(AW), .DW(DW), .CLEAR_EN(1'b1)) dut (
        .ck         (ck),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .reload     (reload),
        .cpu_rst    (cpu_rst),
        .cpu_address(cpu_address),
        .cpu_dataW  (cpu_dataW),
        .cpu_dataR  (cpu_dataR),
        .cpu_ce     (cpu_ce),
        .cpu_we     (cpu_we),
        .ld_count   (ld_count),
        .ovf        (ovf)
    );

    always #5 ck = ~ck;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: an accept or a CPU read in RUN consumes the oldest queued expectation.
    always @(negedge ck) begin
        if (ld_valid && ld_ready) begin
            if (accQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL unexpected_accept: got word 0x%0h, expected no accept", ld_data);
            end else begin
                checkOutput("accept_word", 32'(ld_data), 32'(accQ.pop_front()));
            end
        end
        if (cpu_ce && (cpu_rst === 1'b0)) begin
            if (rdQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL unexpected_read: got 0x%0h, expected no read", cpu_dataR);
            end else begin
                checkOutput("cpu_dataR", 32'(cpu_dataR), 32'(rdQ.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic we,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] expRead);
        cpu_address = addr;
        cpu_ce      = 1'b1;
        cpu_we      = we;
        cpu_dataW   = wdata;
        rdQ.push_back(expRead);
        tick();
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic sendWord(input logic [DW-1:0] d, input logic last, input string name);
        bit got = 1'b0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        accQ.push_back(d);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ck);
            got = (ld_ready === 1'b1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (!got) begin
            void'(accQ.pop_back());
            checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic refuseWord(input logic [DW-1:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = 1'b0;
        @(negedge ck);
        checkOutput("refused_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        ld_valid = 1'b0;
    endtask

    // Counts CLEAR cycles until ld_ready rises, checking cpu_rst is held throughout.
    task automatic expectBoot(input string name);
        int  notReady = 0;
        int  rstBad   = 0;
        bit  seen     = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge ck);
            if (ld_ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                notReady++;
                if (cpu_rst !== 1'b1) rstBad++;
            end
        end
        checkOutput({name, "_clear_cycles"}, 32'(notReady), 32'd256);
        checkOutput({name, "_cpu_rst_held"}, 32'(rstBad), 32'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        ld_valid    = 1'b0;
        ld_data     = '0;
        ld_last     = 1'b0;
        reload      = 1'b0;
        cpu_address = '0;
        cpu_dataW   = '0;
        cpu_ce      = 1'b0;
        cpu_we      = 1'b0;
        repeat (2) @(posedge ck);
        #1 rst = 1'b0;

        // Reset state and a full CLEAR before the first ld_ready.
        checkOutput("rst_ld_count", 32'(ld_count), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd0);
        expectBoot("t1");

        // Three-word image with gaps between words.
        sendWord(16'h0001, 1'b0, "t2_w0");
        repeat (2) tick();
        sendWord(16'h1012, 1'b0, "t2_w1");
        checkOutput("t2_cpu_rst_mid", 32'(cpu_rst), 32'd1);
        repeat (2) tick();
        sendWord(16'h8000, 1'b1, "t2_w2");
        checkOutput("t2_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("t2_ld_count", 32'(ld_count), 32'd3);
        checkOutput("t2_ovf", 32'(ovf), 32'd0);
        checkOutput("t2_ld_ready", 32'(ld_ready), 32'd0);

        // CPU port: same-cycle reads, write returns old data until the next cycle.
        applyStimulus(8'h00, 1'b0, 16'h0000, 16'h0001);
        applyStimulus(8'h01, 1'b0, 16'h0000, 16'h1012);
        applyStimulus(8'h02, 1'b0, 16'h0000, 16'h8000);
        applyStimulus(8'h02, 1'b1, 16'hBEEF, 16'h8000);
        applyStimulus(8'h02, 1'b0, 16'h0000, 16'hBEEF);
        applyStimulus(8'h03, 1'b0, 16'h0000, 16'h0000);

        // Oversized image: 256 taken, the next four refused.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expectBoot("t4");
        for (int i = 0; i < 256; i++) begin
            sendWord(16'hA000 + 16'(i), 1'b0, "t4_w");
        end
        for (int i = 256; i < 260; i++) begin
            refuseWord(16'hA000 + 16'(i));
        end
        checkOutput("t4_ovf", 32'(ovf), 32'd1);
        checkOutput("t4_ld_count", 32'(ld_count), 32'd256);
        checkOutput("t4_cpu_rst", 32'(cpu_rst), 32'd0);
        applyStimulus(8'h00, 1'b0, 16'h0000, 16'hA000);
        applyStimulus(8'h80, 1'b0, 16'h0000, 16'hA080);
        applyStimulus(8'hFF, 1'b0, 16'h0000, 16'hA0FF);

        // Reload from RUN: full CLEAR again, then a one-word image.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checkOutput("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("t5_ld_count", 32'(ld_count), 32'd0);
        checkOutput("t5_ovf", 32'(ovf), 32'd0);
        checkOutput("t5_ld_ready", 32'(ld_ready), 32'd0);
        expectBoot("t5");
        sendWord(16'h5A5A, 1'b1, "t5_w0");
        checkOutput("t5_run_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("t5_run_ld_count", 32'(ld_count), 32'd1);
        checkOutput("t5_run_ovf", 32'(ovf), 32'd0);
        applyStimulus(8'h00, 1'b0, 16'h0000, 16'h5A5A);
        applyStimulus(8'h01, 1'b0, 16'h0000, 16'h0000);
        applyStimulus(8'hFF, 1'b0, 16'h0000, 16'h0000);

        // rst in the middle of a load discards the partial image.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        expectBoot("t6_reload");
        sendWord(16'h1111, 1'b0, "t6_w0");
        sendWord(16'h2222, 1'b0, "t6_w1");
        checkOutput("t6_partial_count", 32'(ld_count), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_ld_count", 32'(ld_count), 32'd0);
        checkOutput("t6_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("t6_ld_ready", 32'(ld_ready), 32'd0);
        expectBoot("t6");
        sendWord(16'h7777, 1'b1, "t6_w2");
        checkOutput("t6_run_ld_count", 32'(ld_count), 32'd1);
        applyStimulus(8'h00, 1'b0, 16'h0000, 16'h7777);
        applyStimulus(8'h01, 1'b0, 16'h0000, 16'h0000);

        tick();
        checkOutput("accq_left", 32'(accQ.size()), 32'd0);
        checkOutput("rdq_left", 32'(rdQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
